// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// moore_decode gives the per-state datapath controls before any Mem_Ready/Zero qualification.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic ctrl_t moore_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_ctrl = ALU_ADD; c.pc_src = PC_ALU; end
      S_DECODE:   begin c.alu_src_b = SRCB_IMM_SH; c.alu_ctrl = ALU_ADD; end
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_ctrl = ALU_ADD; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; end
      S_ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:   begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_ctrl = ALU_SUB;
        c.pc_src = PC_ALUOUT; c.branch = 1'b1;
      end
      S_ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_ctrl = ALU_ADD; end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP:     begin c.pc_src = PC_JUMP; c.pc_write = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_alu_dec.sv
// Funct field to ALUControl decoder for R-type execute; flags any funct the ALU cannot perform.
module mips_mc_alu_dec
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait states and timeout abort.
// Define MIPS_MC_PERF_CNT_EN to add the Cycle_Cnt / Instr_Cnt performance counters.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int WAIT_MAX = 15
`ifdef MIPS_MC_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic             Mem_Req,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCEn,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Illegal,
  output logic             Mem_Err,
  output logic [3:0]       State
`ifdef MIPS_MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] Cycle_Cnt
  , output logic [CNT_W-1:0] Instr_Cnt
`endif
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_state, abort, op_illegal, fn_illegal;
  logic [2:0] fn_alu;

  mips_mc_alu_dec u_alu_dec (
    .funct    (Funct),
    .alu_ctrl (fn_alu),
    .illegal  (fn_illegal)
  );

  always_comb begin
    mem_state  = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    // A ready in the timeout cycle still completes the access.
    abort      = mem_state && !Mem_Ready && (wait_q == WAIT_LIM);
    op_illegal = 1'b0;
    state_d    = state_q;
    case (state_q)
      S_FETCH:    if (Mem_Ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (Mem_Ready) state_d = S_MEMWB; else if (abort) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (Mem_Ready || abort) state_d = S_FETCH;
      S_EXECUTE:  state_d = fn_illegal ? S_FETCH : S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase

    ctrl_d = moore_decode(state_d);

    // A FETCH abort re-enters FETCH, so the abort itself must also clear the count.
    if ((state_d != state_q) || abort)
      wait_d = '0;
    else if (mem_state && !Mem_Ready && (wait_q != WAIT_LIM))
      wait_d = wait_q + 8'd1;
    else
      wait_d = wait_q;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= moore_decode(S_FETCH);
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wait_q  <= wait_d;
    end
  end

  // Every enable and pulse is held off while reset is being sampled.
  always_comb begin
    Mem_Req    = ctrl_q.mem_req & ~abort & Reset;
    MemWrite   = ctrl_q.mem_write & ~abort & Reset;
    IorD       = ctrl_q.iord;
    IRWrite    = (state_q == S_FETCH) & Mem_Ready & Reset;
    PCEn       = (((state_q == S_FETCH) & Mem_Ready) | ctrl_q.pc_write | (ctrl_q.branch & Zero)) & Reset;
    PCSrc      = ctrl_q.pc_src;
    ALUSrcA    = ctrl_q.alu_src_a;
    ALUSrcB    = ctrl_q.alu_src_b;
    ALUControl = (state_q == S_EXECUTE) ? fn_alu : ctrl_q.alu_ctrl;
    RegDst     = ctrl_q.reg_dst;
    MemtoReg   = ctrl_q.mem_to_reg;
    RegWrite   = ctrl_q.reg_write & Reset;
    Illegal    = (op_illegal | ((state_q == S_EXECUTE) & fn_illegal)) & Reset;
    Mem_Err    = abort & Reset;
    State      = state_q;
  end

`ifdef MIPS_MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;
  logic             retire;

  always_comb begin
    retire = (state_q inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP}) ||
             ((state_q == S_MEMWRITE) && Mem_Ready);
    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign Cycle_Cnt = cycle_cnt_q;
  assign Instr_Cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected control vectors are queued as stimulus
// is applied and compared against the DUT outputs mid-cycle.
module tb_mips_multicycle_ctrl;

  localparam int WAIT_MAX = 15;
  localparam int VW = 22;

  logic       clk = 1'b0;
  logic       Reset, Zero, Mem_Ready;
  logic [5:0] Opcode, Funct;
  logic       Mem_Req, MemWrite, IorD, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite;
  logic       Illegal, Mem_Err;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] State;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] Cycle_Cnt, Instr_Cnt;
`endif

  logic [VW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;
  int exp_instr = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .CLK(clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Mem_Ready(Mem_Ready), .Mem_Req(Mem_Req), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Illegal(Illegal), .Mem_Err(Mem_Err), .State(State)
`ifdef MIPS_MC_PERF_CNT_EN
    , .Cycle_Cnt(Cycle_Cnt), .Instr_Cnt(Instr_Cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] mk(
    input logic [3:0] st, input logic req, mw, iord, irw, pcen, input logic [1:0] pcsrc,
    input logic asa, input logic [1:0] asb, input logic [2:0] aluc,
    input logic rdst, m2r, rw, ill, merr);
    return {st, req, mw, iord, irw, pcen, pcsrc, asa, asb, aluc, rdst, m2r, rw, ill, merr};
  endfunction

  function automatic logic [VW-1:0] e_fetch(input logic rdy);
    return mk(4'd0, 1, 0, 0, rdy, rdy, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [VW-1:0] e_decode(input logic ill);
    return mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, ill, 0);
  endfunction
  function automatic logic [VW-1:0] e_mem(input logic [3:0] st);
    return mk(st, 1, st == 4'd5, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [VW-1:0] e_abort(input logic [3:0] st);
    if (st == 4'd0) return mk(4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 1);
    return mk(st, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1);
  endfunction

  function automatic logic [VW-1:0] observed();
    return {State, Mem_Req, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
            ALUControl, RegDst, MemtoReg, RegWrite, Illegal, Mem_Err};
  endfunction

  // Inputs are already set (just after a falling edge); compare, then move to the next falling edge.
  task automatic cyc(input logic [VW-1:0] exp, input string tag);
    exp_q.push_back(exp);
    #1;
    check(tag, 32'(observed()), 32'(exp_q.pop_front()));
    n_cyc++;
    @(negedge clk);
  endtask

  // Non-memory cycle: Mem_Ready is randomised since it must be ignored.
  task automatic cyc_x(input logic [VW-1:0] exp, input string tag);
    Mem_Ready = 1'($urandom_range(0, 1));
    cyc(exp, tag);
  endtask

  task automatic mem_phase(input logic [3:0] st, input int waits, output logic done);
    for (int i = 0; i < waits && i < WAIT_MAX; i++) begin
      Mem_Ready = 1'b0;
      cyc(e_mem(st), "mem_wait");
    end
    if (waits > WAIT_MAX) begin
      Mem_Ready = 1'b0;
      cyc(e_abort(st), "mem_abort");
      done = 1'b0;
    end else begin
      Mem_Ready = 1'b1;
      cyc(e_mem(st), "mem_done");
      done = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int dw);
    logic       done;
    logic [2:0] ac;
    logic       fill;
    Opcode = op; Funct = fn; Zero = z;
    for (int i = 0; i < fw && i < WAIT_MAX; i++) begin
      Mem_Ready = 1'b0;
      cyc(e_fetch(1'b0), "fetch_wait");
    end
    if (fw > WAIT_MAX) begin
      Mem_Ready = 1'b0;
      cyc(e_abort(4'd0), "fetch_abort");
    end
    Mem_Ready = 1'b1;
    cyc(e_fetch(1'b1), "fetch");
    case (op)
      6'b100011: begin
        cyc_x(e_decode(1'b0), "decode_lw");
        cyc_x(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0), "memadr");
        mem_phase(4'd3, dw, done);
        if (done) begin
          cyc_x(mk(4'd4, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 0, 0), "memwb");
          exp_instr++;
        end
      end
      6'b101011: begin
        cyc_x(e_decode(1'b0), "decode_sw");
        cyc_x(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0), "memadr");
        mem_phase(4'd5, dw, done);
        if (done) exp_instr++;
      end
      6'b000000: begin
        fill = 1'b0;
        case (fn)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default: begin ac = 3'b010; fill = 1'b1; end
        endcase
        cyc_x(e_decode(1'b0), "decode_r");
        cyc_x(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, ac, 0, 0, 0, fill, 0), "execute");
        if (!fill) begin
          cyc_x(mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 0, 0), "aluwb");
          exp_instr++;
        end
      end
      6'b000100: begin
        cyc_x(e_decode(1'b0), "decode_beq");
        cyc_x(mk(4'd8, 0, 0, 0, 0, z, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0, 0), "branch");
        exp_instr++;
      end
      6'b001000: begin
        cyc_x(e_decode(1'b0), "decode_addi");
        cyc_x(mk(4'd9, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0), "addiexec");
        cyc_x(mk(4'd10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1, 0, 0), "addiwb");
        exp_instr++;
      end
      6'b000010: begin
        cyc_x(e_decode(1'b0), "decode_j");
        cyc_x(mk(4'd11, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0), "jump");
        exp_instr++;
      end
      default: cyc_x(e_decode(1'b1), "decode_illegal");
    endcase
  endtask

  logic [5:0] op_tab [7];
  logic [5:0] fn_tab [6];

  initial begin
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b001101};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    Reset = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0; Mem_Ready = 1'b1;

    // Reset held for two edges; the second reset cycle shows FETCH with enables suppressed.
    @(posedge clk);
    @(negedge clk);
    cyc(mk(4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0), "reset");
    Reset = 1'b1;
    n_cyc = 0; exp_instr = 0;

    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);
    run_instr(6'b101011, 6'b000000, 1'b0, 0, WAIT_MAX + 1);
    run_instr(6'b100011, 6'b000000, 1'b0, 0, WAIT_MAX);
    run_instr(6'b100011, 6'b000000, 1'b0, 2, WAIT_MAX + 1);
    run_instr(6'b001000, 6'b000000, 1'b0, WAIT_MAX + 1, 0);
    run_instr(6'b000000, 6'b101010, 1'b0, WAIT_MAX, 0);

    // Reset landing in MEMREAD with Mem_Ready high: no request, no enables.
    Opcode = 6'b100011; Mem_Ready = 1'b1;
    cyc(e_fetch(1'b1), "fetch");
    cyc(e_decode(1'b0), "decode_lw");
    cyc(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0), "memadr");
    Reset = 1'b0;
    cyc(mk(4'd3, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0), "rst_mid");
    Reset = 1'b1;
    n_cyc = 0; exp_instr = 0;

    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
`ifdef MIPS_MC_PERF_CNT_EN
    check("instr_cnt", Instr_Cnt, 32'd2);
    check("cycle_cnt", Cycle_Cnt, 32'(n_cyc));
`endif

    for (int k = 0; k < 16; k++) begin
      run_instr(op_tab[$urandom_range(0, 6)], fn_tab[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
`ifdef MIPS_MC_PERF_CNT_EN
    check("instr_cnt_rand", Instr_Cnt, 32'(exp_instr));
    check("cycle_cnt_rand", Cycle_Cnt, 32'(n_cyc));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
